// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU operand/result sequencer.
// Optional build macro: FPU_SEQ_STATUS_EN (appends a status byte to each result).
package fpu_seq_pkg;

   localparam int unsigned DEF_NUM_OPS     = 4;
   localparam int unsigned DEF_OP_W        = 32;
   localparam int unsigned DEF_FPU_LATENCY = 3;

   localparam int unsigned BYTES_IN = DEF_NUM_OPS * DEF_OP_W / 8;
`ifdef FPU_SEQ_STATUS_EN
   localparam int unsigned BYTES_OUT = DEF_OP_W / 8 + 1;
`else
   localparam int unsigned BYTES_OUT = DEF_OP_W / 8;
`endif

   // Bits needed for a counter that runs 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned IN_CNT_W  = cnt_w(BYTES_IN);
   localparam int unsigned SEL_CNT_W = cnt_w(BYTES_OUT);
   localparam int unsigned LAT_CNT_W = cnt_w(DEF_FPU_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_SEND = 2'd3
   } state_t;

endpackage

// File: rtl/fpu_seq_ser.sv
// Result register and byte serialiser with valid/ready output handshake.
// Optional build macro: FPU_SEQ_STATUS_EN (extra status byte after the result).
module fpu_seq_ser
   import fpu_seq_pkg::*;
#(
   parameter int unsigned OP_W = DEF_OP_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            clear,
   input  logic [OP_W-1:0] result,
`ifdef FPU_SEQ_STATUS_EN
   input  logic            overrun,
`endif
   input  logic            byte_out_ready,
   output logic [7:0]      byte_out,
   output logic            byte_out_valid,
   output logic            done
);

   localparam int unsigned RES_BYTES = OP_W / 8;
`ifdef FPU_SEQ_STATUS_EN
   localparam int unsigned N_OUT = RES_BYTES + 1;
`else
   localparam int unsigned N_OUT = RES_BYTES;
`endif
   localparam int unsigned SEL_W = cnt_w(N_OUT);

   logic [OP_W-1:0]  res_q;
   logic [SEL_W-1:0] sel_q;
   logic             active_q;
   logic             last;
   logic [OP_W-1:0]  res_shift;

   assign last           = (sel_q == SEL_W'(N_OUT - 1));
   assign done           = active_q && byte_out_ready && last;
   assign byte_out_valid = active_q;
   assign res_shift      = res_q >> {sel_q, 3'b000};

   // Capture the result on start, then step through its bytes on each accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q    <= '0;
         sel_q    <= '0;
         active_q <= 1'b0;
      end else if (clear) begin
         sel_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         res_q    <= result;
         sel_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q && byte_out_ready) begin
         if (last) begin
            sel_q    <= '0;
            active_q <= 1'b0;
         end else begin
            sel_q <= sel_q + 1'b1;
         end
      end
   end

   // Select the current output byte, LSB first; held constant while ready is low.
   always_comb begin
      byte_out = '0;
      if (active_q) begin
         byte_out = res_shift[7:0];
`ifdef FPU_SEQ_STATUS_EN
         if (sel_q == SEL_W'(RES_BYTES))
            byte_out = {6'b0, (res_q[OP_W-2 -: 8] == 8'hFF), overrun};
`endif
      end
   end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Sequencer: byte-stream operand loader, FPU launch/latency timer, result serialiser.
// Optional build macro: FPU_SEQ_STATUS_EN (result followed by a status byte).
module fpu_seq_ctrl
   import fpu_seq_pkg::*;
#(
   parameter int unsigned NUM_OPS     = DEF_NUM_OPS,
   parameter int unsigned OP_W        = DEF_OP_W,
   parameter int unsigned FPU_LATENCY = DEF_FPU_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              byte_in,
   input  logic                    byte_in_valid,
   input  logic                    abort,
   output logic [NUM_OPS*OP_W-1:0] opnd_flat,
   output logic                    fpu_go,
   input  logic [OP_W-1:0]         fpu_result,
   output logic [7:0]              byte_out,
   output logic                    byte_out_valid,
   input  logic                    byte_out_ready,
   output logic                    busy,
   output logic                    overrun
);

   localparam int unsigned N_BITS = NUM_OPS * OP_W;
   localparam int unsigned N_IN   = N_BITS / 8;
   localparam int unsigned IN_W   = cnt_w(N_IN);
   localparam int unsigned LAT_W  = cnt_w(FPU_LATENCY);

   state_t           state_q, state_d;
   logic [IN_W-1:0]  in_cnt_q;
   logic [LAT_W-1:0] lat_cnt_q;
   logic             ser_start;
   logic             ser_done;
   logic             accepting;

   assign busy      = (state_q != S_IDLE);
   assign accepting = (state_q == S_IDLE) || (state_q == S_LOAD);

   // Next-state decode; abort overrides everything and suppresses launch/capture.
   always_comb begin
      state_d   = state_q;
      fpu_go    = 1'b0;
      ser_start = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (byte_in_valid) state_d = (N_IN == 1) ? S_WAIT : S_LOAD;
            S_LOAD: if (byte_in_valid && in_cnt_q == IN_W'(N_IN - 1)) state_d = S_WAIT;
            S_WAIT: begin
               fpu_go = (lat_cnt_q == '0);
               if (lat_cnt_q == LAT_W'(FPU_LATENCY - 1)) begin
                  ser_start = 1'b1;
                  state_d   = S_SEND;
               end
            end
            S_SEND: if (ser_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State register, operand shifter, byte/latency counters and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         in_cnt_q  <= '0;
         lat_cnt_q <= '0;
         opnd_flat <= '0;
         overrun   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (abort) begin
            in_cnt_q  <= '0;
            lat_cnt_q <= '0;
         end else begin
            if (byte_in_valid && accepting) begin
               opnd_flat <= {opnd_flat[N_BITS-9:0], byte_in};
               in_cnt_q  <= (state_d == S_LOAD) ? in_cnt_q + 1'b1 : '0;
            end
            if (byte_in_valid && !accepting)
               overrun <= 1'b1;
            lat_cnt_q <= (state_q == S_WAIT && state_d == S_WAIT) ? lat_cnt_q + 1'b1 : '0;
         end
      end
   end

   fpu_seq_ser #(
      .OP_W (OP_W)
   ) u_ser (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (ser_start),
      .clear          (abort),
      .result         (fpu_result),
`ifdef FPU_SEQ_STATUS_EN
      .overrun        (overrun),
`endif
      .byte_out_ready (byte_out_ready),
      .byte_out       (byte_out),
      .byte_out_valid (byte_out_valid),
      .done           (ser_done)
   );

endmodule
